// File: rtl/uart_pkg.sv
// Shared types for the UART receive packet path.
// Holds the packet FSM state encoding and the default frame marker.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_LEN,
        ST_PAYLOAD,
        ST_CHK,
        ST_HOLD
    } rx_pkt_state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/rx_timeout_timer.sv
// Inter-byte gap counter for the packet receiver.
// Saturates at TIMEOUT; expired is only meaningful while enabled.
module rx_timeout_timer #(
    parameter int TIMEOUT = 2047
) (
    input  logic clk_uart,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk_uart) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (enable && (cnt != LIMIT)) begin
            cnt <= cnt + TW'(1);
        end
    end

    assign expired = enable && (cnt == LIMIT);

endmodule

// File: rtl/uart_rx_packet_ctrl.sv
// Frames the UART byte stream into SYNC/CMD/LEN/payload/CHK packets
// and hands validated packets to the command decoder over valid/ready.
module uart_rx_packet_ctrl
    import uart_pkg::*;
#(
    parameter int         MAX_LEN   = 16,
    parameter int         TIMEOUT   = 2047,
    parameter logic [7:0] SYNC_BYTE = SYNC_DEFAULT
) (
    input  logic                         clk_uart,
    input  logic                         rst,
    input  logic                         next_byte,
    input  logic [7:0]                   rx_data,
    output logic                         pkt_valid,
    input  logic                         pkt_ready,
    output logic [7:0]                   pkt_cmd,
    output logic [$clog2(MAX_LEN+1)-1:0] pkt_len,
    output logic [8*MAX_LEN-1:0]         pkt_payload,
    output logic                         err_len,
    output logic                         err_chk,
    output logic                         err_timeout,
    output logic                         err_overrun
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam logic [7:0] MAX8 = 8'(MAX_LEN);

    rx_pkt_state_t state, state_next;

    logic [7:0]    acc;
    logic [IW-1:0] idx;
    logic          expired;
    logic          tmr_clear;
    logic          tmr_en;
    logic          last;
    logic          len_bad;
    logic          chk_bad;
    logic          to_hit;
    logic          ovr;

    assign tmr_en = (state == ST_CMD) || (state == ST_LEN) ||
                    (state == ST_PAYLOAD) || (state == ST_CHK);
    assign tmr_clear = next_byte ||
                       ((state != ST_CMD) && (state_next == ST_CMD));
    assign last = (LW'(idx) == (pkt_len - LW'(1)));

    rx_timeout_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk_uart (clk_uart),
        .rst      (rst),
        .clear    (tmr_clear),
        .enable   (tmr_en),
        .expired  (expired)
    );

    always_ff @(posedge clk_uart) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        len_bad    = 1'b0;
        chk_bad    = 1'b0;
        ovr        = 1'b0;
        to_hit     = expired && !next_byte;
        unique case (state)
            ST_IDLE: begin
                if (next_byte && (rx_data == SYNC_BYTE)) begin
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (next_byte) state_next = ST_LEN;
            end
            ST_LEN: begin
                if (next_byte) begin
                    unique case (1'b1)
                        (rx_data > MAX8): begin
                            len_bad    = 1'b1;
                            state_next = ST_IDLE;
                        end
                        (rx_data == 8'd0): state_next = ST_CHK;
                        default:           state_next = ST_PAYLOAD;
                    endcase
                end
            end
            ST_PAYLOAD: begin
                if (next_byte && last) state_next = ST_CHK;
            end
            ST_CHK: begin
                if (next_byte) begin
                    if (rx_data == acc) begin
                        state_next = ST_HOLD;
                    end else begin
                        chk_bad    = 1'b1;
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_HOLD: begin
                if (pkt_ready) begin
                    // A byte landing on the handshake starts the next frame
                    if (next_byte && (rx_data == SYNC_BYTE)) begin
                        state_next = ST_CMD;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (next_byte) begin
                    ovr = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        if (to_hit) state_next = ST_IDLE;
    end

    always_comb begin
        pkt_valid = (state == ST_HOLD);
    end

    always_ff @(posedge clk_uart) begin
        if (rst) begin
            err_len     <= 1'b0;
            err_chk     <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_len     <= len_bad;
            err_chk     <= chk_bad;
            err_timeout <= to_hit;
            err_overrun <= ovr;
        end
    end

    always_ff @(posedge clk_uart) begin
        if (rst) begin
            pkt_cmd     <= '0;
            pkt_len     <= '0;
            pkt_payload <= '0;
            acc         <= '0;
            idx         <= '0;
        end else if (next_byte) begin
            unique case (state)
                ST_CMD: begin
                    pkt_cmd     <= rx_data;
                    acc         <= rx_data;
                    pkt_payload <= '0;
                end
                ST_LEN: begin
                    if (!len_bad) begin
                        pkt_len <= rx_data[LW-1:0];
                        acc     <= acc ^ rx_data;
                        idx     <= '0;
                    end
                end
                ST_PAYLOAD: begin
                    pkt_payload[idx*8 +: 8] <= rx_data;
                    acc <= acc ^ rx_data;
                    idx <= idx + IW'(1);
                end
                default: ;
            endcase
        end
    end

endmodule
